// File: rtl/riscv_sys_responder.sv
// Program loader, instruction/data memory and register file serving riscv_proc.
// Define RISCV_RESP_DMEM_CHECK_EN to fault on misaligned or out-of-range data accesses.
module riscv_sys_responder #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        cpu_reset,
    input  logic [31:0] PC,
    output logic [31:0] instruction,
    input  logic [4:0]  regfile_raddr1,
    input  logic [4:0]  regfile_raddr2,
    output logic [31:0] regfile_rdata1,
    output logic [31:0] regfile_rdata2,
    input  logic        regfile_write,
    input  logic [4:0]  regfile_waddr,
    input  logic [31:0] regfile_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] data_mem_addr,
    input  logic [31:0] data_mem_wdata,
    output logic [31:0] data_mem_rdata,
    output logic        halted,
    output logic        fault,
    output logic [31:0] cycle_count
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);
    localparam logic [IAW:0] PTR_FULL = (IAW+1)'(IMEM_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

    state_t state, state_nxt;
    logic [IAW:0] ptr;
    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] regs [32];
    logic [31:0] dmem [DMEM_WORDS];

    logic running, load_fire, load_full, imem_we;
    logic pc_fault, dmem_fault, halt_set, fault_set;
    logic [IAW-1:0] iidx;
    logic [DAW-1:0] didx;

    assign load_ready = (state == LOAD);

    always_comb begin
        running = (state == RUN);
        load_fire = load_valid && load_ready;
        load_full = (ptr == PTR_FULL);
        imem_we = load_fire && !load_full;
        iidx = PC[IAW+1:2];
        didx = data_mem_addr[DAW+1:2];
        instruction = running ? imem[iidx] : NOP;
        pc_fault = running && ((PC[1:0] != 2'b00)
                   || (PC[31:2] >= 30'(IMEM_WORDS)));
`ifdef RISCV_RESP_DMEM_CHECK_EN
        dmem_fault = running && (mem_read || mem_write)
                     && ((data_mem_addr[1:0] != 2'b00)
                     || (data_mem_addr[31:2] >= 30'(DMEM_WORDS)));
`else
        dmem_fault = 1'b0;
`endif
        data_mem_rdata = (running && mem_read && !dmem_fault) ? dmem[didx] : '0;
        regfile_rdata1 = (regfile_raddr1 == 5'd0) ? '0 : regs[regfile_raddr1];
        regfile_rdata2 = (regfile_raddr2 == 5'd0) ? '0 : regs[regfile_raddr2];
    end

`ifndef RISCV_RESP_DMEM_CHECK_EN
    // Without checking, high and low address bits simply do not select anything.
    logic unused_addr;
    assign unused_addr = ^{data_mem_addr[31:DAW+2], data_mem_addr[1:0]};
`endif

    always_comb begin
        state_nxt = state;
        halt_set = 1'b0;
        fault_set = 1'b0;
        unique case (state)
            LOAD: begin
                if (load_fire) begin
                    if (load_full) begin
                        state_nxt = HALT;
                        fault_set = 1'b1;
                    end else if (load_last) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (pc_fault || dmem_fault) begin
                    state_nxt = HALT;
                    fault_set = 1'b1;
                end else if (instruction == EBREAK) begin
                    state_nxt = HALT;
                    halt_set = 1'b1;
                end
            end
            HALT: state_nxt = HALT;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
            cpu_reset <= 1'b1;
            halted <= 1'b0;
            fault <= 1'b0;
            cycle_count <= '0;
            ptr <= '0;
        end else begin
            state <= state_nxt;
            cpu_reset <= (state_nxt != RUN);
            halted <= halted | halt_set | fault_set;
            fault <= fault | fault_set;
            if (running && (cycle_count != '1))
                cycle_count <= cycle_count + 32'd1;
            if (imem_we)
                ptr <= ptr + (IAW+1)'(1);
        end
    end

    // Program image deliberately survives reset so a core can be re-run.
    always_ff @(posedge clk) begin
        if (imem_we && !reset)
            imem[ptr[IAW-1:0]] <= load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (running && regfile_write && (regfile_waddr != 5'd0)) begin
            regs[regfile_waddr] <= regfile_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_WORDS; i++)
                dmem[i] <= '0;
        end else if (running && mem_write && !dmem_fault) begin
            dmem[didx] <= data_mem_wdata;
        end
    end
endmodule

// File: tb/tb_riscv_sys_responder.sv
// Directed bench for riscv_sys_responder: a memory/register model is checked
// against the DUT on every falling edge, plus hand-computed literal expectations.
module tb_riscv_sys_responder;
    localparam int IW = 256;
    localparam int DW = 256;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid, load_last, load_ready, cpu_reset;
    logic [31:0] load_data, PC, instruction;
    logic [4:0]  regfile_raddr1, regfile_raddr2, regfile_waddr;
    logic [31:0] regfile_rdata1, regfile_rdata2, regfile_wdata;
    logic        regfile_write, mem_read, mem_write;
    logic [31:0] data_mem_addr, data_mem_wdata, data_mem_rdata;
    logic        halted, fault;
    logic [31:0] cycle_count;

    riscv_sys_responder #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready),
        .cpu_reset(cpu_reset), .PC(PC), .instruction(instruction),
        .regfile_raddr1(regfile_raddr1), .regfile_raddr2(regfile_raddr2),
        .regfile_rdata1(regfile_rdata1), .regfile_rdata2(regfile_rdata2),
        .regfile_write(regfile_write), .regfile_waddr(regfile_waddr),
        .regfile_wdata(regfile_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .data_mem_addr(data_mem_addr),
        .data_mem_wdata(data_mem_wdata), .data_mem_rdata(data_mem_rdata),
        .halted(halted), .fault(fault), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: loading / running / stopped, with plain arrays for storage.
    logic [31:0] m_imem [IW];
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [DW];
    bit m_run, m_halted, m_fault;
    int m_ptr;
    logic [31:0] m_cycles;
    bit mp_bad, md_bad;

    task automatic m_reset();
        m_run = 0;
        m_halted = 0;
        m_fault = 0;
        m_ptr = 0;
        m_cycles = 0;
        foreach (m_regs[i]) m_regs[i] = 0;
        foreach (m_dmem[i]) m_dmem[i] = 0;
    endtask

    function automatic bit e_pc_oob();
        return (PC >> 2) >= IW;
    endfunction

    function automatic logic [31:0] e_instr();
        if (!m_run) return NOP;
        return m_imem[(PC >> 2) % IW];
    endfunction

    function automatic bit e_dbad();
`ifdef RISCV_RESP_DMEM_CHECK_EN
        return m_run && (mem_read || mem_write)
               && ((data_mem_addr % 4 != 0) || ((data_mem_addr >> 2) >= DW));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] e_rdata();
        if (m_run && mem_read && !e_dbad())
            return m_dmem[(data_mem_addr >> 2) % DW];
        return 32'h0;
    endfunction

    function automatic logic [31:0] e_reg(input logic [4:0] a);
        return (a == 0) ? 32'h0 : m_regs[a];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reset();
        end else if (!m_run && !m_halted) begin
            if (load_valid) begin
                if (m_ptr == IW) begin
                    m_halted = 1;
                    m_fault = 1;
                end else begin
                    m_imem[m_ptr] = load_data;
                    m_ptr++;
                    if (load_last) m_run = 1;
                end
            end
        end else if (m_run) begin
            if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
            mp_bad = (PC % 4 != 0) || e_pc_oob();
            md_bad = e_dbad();
            if (regfile_write && regfile_waddr != 0)
                m_regs[regfile_waddr] = regfile_wdata;
            if (mem_write && !md_bad)
                m_dmem[(data_mem_addr >> 2) % DW] = data_mem_wdata;
            if (mp_bad || md_bad) begin
                m_run = 0;
                m_halted = 1;
                m_fault = 1;
            end else if (m_imem[(PC >> 2) % IW] == EBRK) begin
                m_run = 0;
                m_halted = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("load_ready", load_ready, !m_run && !m_halted);
            chk("cpu_reset", cpu_reset, !m_run);
            chk("halted", halted, m_halted);
            chk("fault", fault, m_fault);
            chk("cycle_count", cycle_count, m_cycles);
            if (!(m_run && e_pc_oob()))
                chk("instruction", instruction, e_instr());
            chk("rdata1", regfile_rdata1, e_reg(regfile_raddr1));
            chk("rdata2", regfile_rdata2, e_reg(regfile_raddr2));
            chk("dmem_rdata", data_mem_rdata, e_rdata());
        end
    end

    task automatic idle();
        load_valid = 0; load_data = 0; load_last = 0; PC = 0;
        regfile_raddr1 = 0; regfile_raddr2 = 0; regfile_write = 0;
        regfile_waddr = 0; regfile_wdata = 0; mem_read = 0; mem_write = 0;
        data_mem_addr = 0; data_mem_wdata = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w, input bit last);
        load_valid = 1;
        load_data = w;
        load_last = last;
        step();
        load_valid = 0;
        load_last = 0;
    endtask

    // Async reset pulse placed between edges; outputs must clear without a clock.
    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1;
        #1;
        chk("rst cpu_reset", cpu_reset, 1);
        chk("rst load_ready", load_ready, 1);
        chk("rst instruction", instruction, NOP);
        chk("rst cycle_count", cycle_count, 0);
        chk("rst halted", {halted, fault}, 0);
        chk("rst dmem_rdata", data_mem_rdata, 0);
        #1 reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        m_reset();
        #1 reset = 1;
        #11;
        chk("reset cpu_reset", cpu_reset, 1);
        chk("reset load_ready", load_ready, 1);
        chk("reset instruction", instruction, NOP);
        chk("reset cycle_count", cycle_count, 0);
        chk("reset flags", {halted, fault}, 0);
        chk("reset rdata", regfile_rdata1 | data_mem_rdata, 0);
        @(negedge clk);
        reset = 0;
        cmp_en = 1;

        // Program: addi x1,x0,5 ; sw x1,8(x0) ; ebreak
        load_word(32'h0050_0093, 0);
        load_word(32'h0010_2423, 0);
        load_word(EBRK, 1);
        chk("run load_ready", load_ready, 0);
        chk("run cpu_reset", cpu_reset, 0);
        PC = 0; regfile_write = 1; regfile_waddr = 1; regfile_wdata = 5;
        @(negedge clk);
        chk("fetch addi", instruction, 32'h0050_0093);
        step();
        idle();
        PC = 4; regfile_raddr2 = 1; mem_write = 1;
        data_mem_addr = 8; data_mem_wdata = 5;
        @(negedge clk);
        chk("x1 after addi", regfile_rdata2, 5);
        chk("fetch sw", instruction, 32'h0010_2423);
        step();
        idle();
        PC = 8; mem_read = 1; data_mem_addr = 8;
        @(negedge clk);
        chk("dmem[2] read", data_mem_rdata, 5);
        chk("fetch ebreak", instruction, EBRK);
        step();
        idle();
        regfile_raddr1 = 1;
        #1;
        chk("ebreak halted", halted, 1);
        chk("ebreak fault", fault, 0);
        chk("ebreak cycles", cycle_count, 3);
        chk("halt cpu_reset", cpu_reset, 1);
        chk("x1 in halt", regfile_rdata1, 5);
        chk("model x1", m_regs[1], 5);
        chk("model dmem2", m_dmem[2], 5);

        // x0 write is dropped; same-cycle write/read returns the old value.
        pulse_reset();
        idle();
        for (int i = 0; i < 7; i++)
            load_word(NOP | (32'(i) << 7), 0);
        load_word(EBRK, 1);
        PC = 0; regfile_write = 1; regfile_waddr = 0; regfile_wdata = 32'hDEAD_BEEF;
        step();
        idle();
        PC = 4; regfile_raddr1 = 0; regfile_raddr2 = 7;
        regfile_write = 1; regfile_waddr = 7; regfile_wdata = 9;
        @(negedge clk);
        chk("x0 reads 0", regfile_rdata1, 0);
        chk("x7 pre-write", regfile_rdata2, 0);
        step();
        idle();
        PC = 8; regfile_raddr2 = 7;
        @(negedge clk);
        chk("x7 post-write", regfile_rdata2, 9);
        step();
        idle();
        PC = 32'h0000_0402;
        @(negedge clk);
        chk("pc fault pending", fault, 0);
        step();
        chk("pc fault", fault, 1);
        chk("pc fault halted", halted, 1);
        chk("pc fault cycles", cycle_count, 4);
        step();
        step();
        chk("cycles frozen", cycle_count, 4);
        chk("fault cpu_reset", cpu_reset, 1);

        // Reload restarts at imem[0]; then reset lands in the middle of a run.
        pulse_reset();
        idle();
        load_word(32'h0020_0113, 0);
        load_word(NOP, 0);
        load_word(EBRK, 1);
        @(negedge clk);
        chk("reload imem0", instruction, 32'h0020_0113);
        step();
        PC = 4; regfile_write = 1; regfile_waddr = 2; regfile_wdata = 7;
        regfile_raddr1 = 2;
        step();
        chk("midrun cycles", cycle_count, 2);
        chk("midrun x2", regfile_rdata1, 7);
        pulse_reset();
        chk("midrun x2 cleared", regfile_rdata1, 0);
        idle();

        // Store to one word past the end of data memory.
        load_word(NOP, 0);
        load_word(EBRK, 1);
        PC = 0; mem_write = 1;
        data_mem_addr = 4 * DW; data_mem_wdata = 32'hA5A5_0001;
        step();
        idle();
`ifdef RISCV_RESP_DMEM_CHECK_EN
        chk("dmem oob fault", fault, 1);
        chk("dmem oob halted", halted, 1);
        chk("dmem oob cycles", cycle_count, 1);
        chk("model dmem0 kept", m_dmem[0], 0);
`else
        chk("dmem wrap no fault", fault, 0);
        PC = 4; mem_read = 1; data_mem_addr = 0;
        @(negedge clk);
        chk("dmem wrap to 0", data_mem_rdata, 32'hA5A5_0001);
        step();
        idle();
        chk("wrap run halted", halted, 1);
`endif

        // Overflowing the load stream faults without leaving reset.
        pulse_reset();
        idle();
        for (int i = 0; i < IW; i++)
            load_word(32'(i), 0);
        chk("full no fault", fault, 0);
        chk("full cpu_reset", cpu_reset, 1);
        load_word(32'hFFFF_FFFF, 0);
        chk("overflow fault", fault, 1);
        chk("overflow halted", halted, 1);
        chk("overflow cpu_reset", cpu_reset, 1);
        chk("overflow load_ready", load_ready, 0);
        step();
        step();
        cmp_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_sys_responder.md
# riscv_sys_responder

Memory-and-register-file responder for the `riscv_proc` core. It serves the other end of the core's datapath interface: it returns `instruction`, `data_mem_rdata`, `regfile_rdata1` and `regfile_rdata2`, and it consumes `PC`, the register-file write port and the data-memory port. It contains a program-load FSM that fills instruction memory through a valid/ready stream, holds the core in reset until the load completes, then runs the core until it reaches `ebreak` or a fault. It sits beside `riscv_proc` in the system top and replaces testbench-modelled memories.

## Interface
- `IMEM_WORDS`, 256, instruction memory depth in 32-bit words; power of 2.
- `DMEM_WORDS`, 256, data memory depth in 32-bit words; power of 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  a load word is present.
- `load_data`  in  32  instruction word to store.
- `load_last`  in  1  marks the final load word.
- `load_ready`  out  1  block accepts a load word.
- `cpu_reset`  out  1  reset driven to `riscv_proc`.
- `PC`  in  32  fetch address from the core.
- `instruction`  out  32  fetched instruction.
- `regfile_raddr1`, `regfile_raddr2`  in  5  read addresses.
- `regfile_rdata1`, `regfile_rdata2`  out  32  read data.
- `regfile_write`  in  1  register write enable.
- `regfile_waddr`  in  5  write address.
- `regfile_wdata`  in  32  write data.
- `mem_read`, `mem_write`  in  1  data memory strobes.
- `data_mem_addr`  in  32  byte address.
- `data_mem_wdata`  in  32  store data.
- `data_mem_rdata`  out  32  load data.
- `halted`  out  1  sticky; run ended.
- `fault`  out  1  sticky; run ended abnormally.
- `cycle_count`  out  32  number of RUN cycles.

## Operation
- FSM states and transitions:
  - LOAD: entered from reset.
  - LOAD → RUN: on a load handshake with `load_last` = 1.
  - LOAD → HALT (fault): on a handshake when the load pointer is already `IMEM_WORDS`.
  - RUN → HALT: on `ebreak`, or on a fault.
  - HALT: held until `reset`.
- Load handshake:
  - A transfer occurs when `load_valid & load_ready`.
  - Each transfer writes `imem[ptr]` and increments `ptr`, which resets to 0.
  - `load_ready` = 1 only in LOAD.
- `cpu_reset` = 1 in LOAD and HALT, 0 in RUN. It is a registered output.
- Instruction fetch (combinational):
  - In RUN, `instruction` = `imem[PC[31:2]]`.
  - Outside RUN, `instruction` = 32'h0000_0013 (NOP).
- Fault conditions in RUN:
  - `PC[1:0]` ≠ 0.
  - `PC[31:2]` ≥ `IMEM_WORDS`.
  - On either, set `fault` and `halted`, and go to HALT.
- Halt: when `instruction` = 32'h0010_0073 in RUN, set `halted` and go to HALT.
- Register file:
  - 32×32 registers; x0 always reads 0.
  - Write on the clock edge when `regfile_write`, RUN, and `regfile_waddr` ≠ 0.
  - Reads are combinational and return the pre-write value in a same-cycle read/write.
- Data memory:
  - Word index is `data_mem_addr[31:2]`; `addr[1:0]` is ignored.
  - Write on the clock edge when `mem_write` in RUN.
  - `data_mem_rdata` = `dmem[idx]` when `mem_read` in RUN, else 0.
- Writes in the cycle that causes HALT are honoured. No writes occur in LOAD or HALT.
- `cycle_count` increments on every RUN cycle, saturates at 32'hFFFF_FFFF, and holds in HALT.

## Timing
- Reset values:
  - state = LOAD, `cpu_reset` = 1, `load_ready` = 1.
  - `halted` = 0, `fault` = 0, `cycle_count` = 0, `ptr` = 0.
  - All registers = 0; all dmem words = 0. imem is not cleared.
  - `instruction` = NOP, `data_mem_rdata` = 0, `regfile_rdata*` = 0.
- Load to run:
  - The last handshake occurs at edge N.
  - From edge N: state = RUN, `cpu_reset` = 0, `load_ready` = 0.
  - The first fetch is at PC 0 in the cycle after edge N.
- Read latency:
  - Fetch, register reads and data reads are zero-cycle (combinational).
  - Writes become visible the cycle after the edge.
- Halt or fault: detected combinationally in cycle K. From edge K, state = HALT and `cpu_reset` = 1.
- `reset` asserted mid-run or mid-load:
  - Immediately returns everything to the reset values, without waiting for a clock.
  - imem contents survive, but `ptr` restarts at 0.

## Configuration
- `RISCV_RESP_DMEM_CHECK_EN` defined:
  - A data access (`mem_read` or `mem_write`) with `addr[1:0]` ≠ 0 or `addr[31:2]` ≥ `DMEM_WORDS` in RUN is a fault.
  - The store is suppressed, `data_mem_rdata` = 0, `fault` and `halted` are set, and the block goes to HALT.
- Undefined:
  - The index wraps modulo `DMEM_WORDS`.
  - Low address bits are ignored.
  - No fault is raised by data accesses.

## Test plan
- Load 3 words (`addi x1,x0,5`; `sw x1,8(x0)`; `ebreak`), the last with `load_last` → `load_ready` drops the next cycle and `cpu_reset` = 0; with PC 0/4/8 driven, x1 = 5, dmem[2] = 5, and `halted` = 1, `fault` = 0 after edge 3, `cycle_count` = 3.
- Write x0 = 32'hDEAD_BEEF, then read raddr1 = 0 → 0. Same-cycle write and read of x7 (old 0, new 9) → 0 in that cycle, 9 in the next.
- Offer `IMEM_WORDS`+1 words without `load_last` → `fault` = 1, `halted` = 1, and `cpu_reset` stays 1.
- In RUN, drive PC = 32'h0000_0402 → `fault` asserted at the next edge, `cycle_count` frozen.
- With the macro defined, store to byte address 4×`DMEM_WORDS` → fault, no memory change. Without the macro, the same store lands in dmem[0].
- Assert `reset` asynchronously mid-run → outputs return to reset values before the next edge; reloading restarts from imem[0].
